// File: rtl/uart_frame_parser.sv
// uart_frame_parser: host-link framer for the miner.
// Receive side decodes checksummed command frames into work/target loads and
// loop-test requests. Transmit side serialises checksum NACKs, loop acks and
// found-nonce events into checksummed response frames.
// Found-nonce events are gathered from CHANNELS cores through a round-robin
// arbiter and a small FIFO.
module uart_frame_parser #(
    parameter int WORK_BYTES   = 80,
    parameter int TARGET_BYTES = 4,
    parameter int NONCE_BYTES  = 4,
    parameter int CHANNELS     = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [7:0]                        rx_data,
    input  logic                              new_rx_data,
    output logic [7:0]                        tx_data,
    output logic                              new_tx_data,
    input  logic                              tx_busy,
    output logic                              valid,
    output logic [8*WORK_BYTES-1:0]           work,
    output logic [8*TARGET_BYTES-1:0]         target,
    input  logic [CHANNELS-1:0]               found,
    input  logic [CHANNELS*8*NONCE_BYTES-1:0] nonce,
    output logic [7:0]                        drop_count
);
    localparam int NONCE_W   = 8 * NONCE_BYTES;
    localparam int STAGE_W   = 8 * (WORK_BYTES + TARGET_BYTES);
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W   = 8 + NONCE_W;
    localparam int PAY_BYTES = NONCE_BYTES + 1;
    localparam int PAY_W     = 8 * PAY_BYTES;
    localparam logic [7:0] WORK_LEN  = 8'(WORK_BYTES + TARGET_BYTES);
    localparam logic [7:0] FOUND_LEN = 8'(PAY_BYTES);
    localparam logic [AW:0] FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    // XOR of all payload bytes; unused upper bytes are zero and drop out.
    function automatic logic [7:0] xor_bytes(input logic [PAY_W-1:0] data);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < PAY_BYTES; i++) begin
            acc = acc ^ data[8*i +: 8];
        end
        return acc;
    endfunction

    typedef enum logic [2:0] {RX_IDLE, RX_CMD, RX_LEN, RX_DATA, RX_CHK} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_CMD, TX_LEN, TX_DATA, TX_CHK} tx_state_t;

    rx_state_t                 rx_state_r, rx_next_s;
    logic [7:0]                rx_cmd_r, rx_len_r, rx_cnt_r, rx_chk_r;
    logic [STAGE_W-1:0]        stage_r;
    logic                      load_s, loop_set_s, nack_set_s;
    logic                      valid_r;
    logic [8*WORK_BYTES-1:0]   work_r;
    logic [8*TARGET_BYTES-1:0] target_r;

    logic                      nack_pend_r, loop_pend_r;
    logic [7:0]                nack_cmd_r, loop_data_r;

    logic [CHANNELS-1:0]       pending_r, grant_hit_s, drop_vec_s;
    logic [NONCE_W-1:0]        nonce_r [CHANNELS];
    logic [CW-1:0]             last_r, grant_idx_s;
    logic                      grant_valid_s;
    logic [8:0]                drop_num_s;
    logic [9:0]                drop_sum_s;
    logic [7:0]                drop_count_r, drop_next_s;

    logic [ENTRY_W-1:0]        fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr_r, rd_ptr_r;
    logic [AW:0]               count_r;
    logic                      fifo_full_s, fifo_empty_s, fifo_pop_s;
    logic [ENTRY_W-1:0]        fifo_head_s;

    tx_state_t                 tx_state_r, tx_next_s;
    logic [7:0]                tx_cmd_r, tx_len_r, tx_chk_r, tx_idx_r;
    logic [PAY_W-1:0]          tx_pay_r, frame_pay_s;
    logic [7:0]                frame_cmd_s, frame_len_s, byte_s, pay_byte_s;
    logic                      take_nack_s, take_loop_s, load_frame_s, issue_s, idx_inc_s;
    logic                      busy_d_r, busy_fall_s;
    logic [7:0]                tx_data_r;
    logic                      new_tx_data_r;

    assign valid       = valid_r;
    assign work        = work_r;
    assign target      = target_r;
    assign drop_count  = drop_count_r;
    assign tx_data     = tx_data_r;
    assign new_tx_data = new_tx_data_r;

    // Rx frame decode: next state and end-of-frame actions.
    always_comb begin
        rx_next_s  = rx_state_r;
        load_s     = 1'b0;
        loop_set_s = 1'b0;
        nack_set_s = 1'b0;
        if (new_rx_data) begin
            case (rx_state_r)
                RX_IDLE: rx_next_s = (rx_data == 8'hAA) ? RX_CMD : RX_IDLE;
                RX_CMD:  rx_next_s = (rx_data == 8'h00 || rx_data == 8'h01) ? RX_LEN : RX_IDLE;
                RX_LEN: begin
                    if ((rx_cmd_r == 8'h00 && rx_data == WORK_LEN) ||
                        (rx_cmd_r == 8'h01 && rx_data == 8'h01)) begin
                        rx_next_s = RX_DATA;
                    end else begin
                        rx_next_s = RX_IDLE;
                    end
                end
                RX_DATA: rx_next_s = (rx_cnt_r == rx_len_r - 8'd1) ? RX_CHK : RX_DATA;
                RX_CHK: begin
                    rx_next_s = RX_IDLE;
                    if (rx_chk_r == rx_data) begin
                        load_s     = (rx_cmd_r == 8'h00);
                        loop_set_s = (rx_cmd_r != 8'h00);
                    end else begin
                        nack_set_s = 1'b1;
                    end
                end
                default: rx_next_s = RX_IDLE;
            endcase
        end else begin
            rx_next_s = rx_state_r;
        end
    end

    // Rx state, running checksum, byte counter and staging shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
            rx_cmd_r   <= 8'h00;
            rx_len_r   <= 8'h00;
            rx_cnt_r   <= 8'h00;
            rx_chk_r   <= 8'h00;
            stage_r    <= '0;
            valid_r    <= 1'b0;
            work_r     <= '0;
            target_r   <= '0;
        end else begin
            rx_state_r <= rx_next_s;
            valid_r    <= load_s;
            if (load_s) begin
                work_r   <= stage_r[8*WORK_BYTES-1:0];
                target_r <= stage_r[STAGE_W-1 -: 8*TARGET_BYTES];
            end
            if (new_rx_data) begin
                case (rx_state_r)
                    RX_CMD: begin
                        rx_cmd_r <= rx_data;
                        rx_chk_r <= rx_data;
                    end
                    RX_LEN: begin
                        rx_len_r <= rx_data;
                        rx_chk_r <= rx_chk_r ^ rx_data;
                        rx_cnt_r <= 8'h00;
                    end
                    // Bytes enter at the top, so byte 0 ends at the bottom.
                    RX_DATA: begin
                        stage_r  <= {rx_data, stage_r[STAGE_W-1:8]};
                        rx_chk_r <= rx_chk_r ^ rx_data;
                        rx_cnt_r <= rx_cnt_r + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Response requests; a fresh request wins over a same-cycle take.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            nack_pend_r <= 1'b0;
            nack_cmd_r  <= 8'h00;
            loop_pend_r <= 1'b0;
            loop_data_r <= 8'h00;
        end else begin
            if (take_nack_s) nack_pend_r <= 1'b0;
            if (nack_set_s) begin
                nack_pend_r <= 1'b1;
                nack_cmd_r  <= rx_cmd_r;
            end
            if (take_loop_s) loop_pend_r <= 1'b0;
            if (loop_set_s) begin
                loop_pend_r <= 1'b1;
                loop_data_r <= stage_r[STAGE_W-1 -: 8] + 8'd1;
            end
        end
    end

    // Round-robin arbiter: lowest offset after the last grant wins.
    always_comb begin
        int j;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        grant_hit_s   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            j = int'(last_r) + 1 + i;
            if (j >= CHANNELS) j = j - CHANNELS;
            if (pending_r[j]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = CW'(j);
            end
        end
        grant_valid_s = grant_valid_s & ~fifo_full_s;
        if (grant_valid_s) begin
            grant_hit_s[grant_idx_s] = 1'b1;
        end else begin
            grant_hit_s = '0;
        end
    end

    // Dropped events: found on a channel still pending and not granted now.
    always_comb begin
        drop_vec_s = found & pending_r & ~grant_hit_s;
        drop_num_s = 9'd0;
        for (int c = 0; c < CHANNELS; c++) begin
            drop_num_s = drop_num_s + {8'd0, drop_vec_s[c]};
        end
        drop_sum_s = {2'b00, drop_count_r} + {1'b0, drop_num_s};
        if (drop_sum_s > 10'd255) begin
            drop_next_s = 8'hFF;
        end else begin
            drop_next_s = drop_sum_s[7:0];
        end
    end

    // Per-channel pending flags, nonce latches, drop counter and grant pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_r    <= '0;
            drop_count_r <= 8'h00;
            last_r       <= CW'(CHANNELS - 1);
            for (int c = 0; c < CHANNELS; c++) nonce_r[c] <= '0;
        end else begin
            drop_count_r <= drop_next_s;
            if (grant_valid_s) last_r <= grant_idx_s;
            for (int c = 0; c < CHANNELS; c++) begin
                if (found[c] && !drop_vec_s[c]) begin
                    pending_r[c] <= 1'b1;
                    nonce_r[c]   <= nonce[c*NONCE_W +: NONCE_W];
                end else if (grant_hit_s[c]) begin
                    pending_r[c] <= 1'b0;
                end
            end
        end
    end

    assign fifo_full_s  = (count_r == FIFO_FULL_CNT);
    assign fifo_empty_s = (count_r == '0);
    assign fifo_head_s  = fifo_mem_r[rd_ptr_r];

    // Found-event FIFO; the arbiter never pushes when full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) fifo_mem_r[k] <= '0;
        end else begin
            if (grant_valid_s) begin
                fifo_mem_r[wr_ptr_r] <= {8'(grant_idx_s), nonce_r[grant_idx_s]};
                wr_ptr_r             <= wr_ptr_r + 1'b1;
            end
            if (fifo_pop_s) rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({grant_valid_s, fifo_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign busy_fall_s = busy_d_r & ~tx_busy;

    // Current payload byte, selected without a variable part-select.
    always_comb begin
        pay_byte_s = 8'h00;
        for (int b = 0; b < PAY_BYTES; b++) begin
            pay_byte_s = pay_byte_s | (tx_pay_r[8*b +: 8] & {8{tx_idx_r == 8'(b)}});
        end
    end

    // Tx frame sequencing; a frame is only committed while the transmitter is idle.
    always_comb begin
        tx_next_s    = tx_state_r;
        take_nack_s  = 1'b0;
        take_loop_s  = 1'b0;
        fifo_pop_s   = 1'b0;
        load_frame_s = 1'b0;
        frame_cmd_s  = 8'h00;
        frame_len_s  = 8'h00;
        frame_pay_s  = '0;
        issue_s      = 1'b0;
        idx_inc_s    = 1'b0;
        byte_s       = 8'h00;
        case (tx_state_r)
            TX_IDLE: begin
                if (tx_busy) begin
                    tx_next_s = TX_IDLE;
                end else if (nack_pend_r) begin
                    take_nack_s  = 1'b1;
                    load_frame_s = 1'b1;
                    frame_cmd_s  = 8'h7F;
                    frame_len_s  = 8'h01;
                    frame_pay_s  = PAY_W'(nack_cmd_r);
                    tx_next_s    = TX_HDR;
                end else if (loop_pend_r) begin
                    take_loop_s  = 1'b1;
                    load_frame_s = 1'b1;
                    frame_cmd_s  = 8'h01;
                    frame_len_s  = 8'h01;
                    frame_pay_s  = PAY_W'(loop_data_r);
                    tx_next_s    = TX_HDR;
                end else if (!fifo_empty_s) begin
                    fifo_pop_s   = 1'b1;
                    load_frame_s = 1'b1;
                    frame_cmd_s  = 8'h00;
                    frame_len_s  = FOUND_LEN;
                    frame_pay_s  = {fifo_head_s[NONCE_W-1:0], fifo_head_s[ENTRY_W-1 -: 8]};
                    tx_next_s    = TX_HDR;
                end else begin
                    tx_next_s = TX_IDLE;
                end
            end
            TX_HDR: begin
                if (!tx_busy) begin
                    issue_s   = 1'b1;
                    byte_s    = 8'h55;
                    tx_next_s = TX_CMD;
                end else begin
                    tx_next_s = TX_HDR;
                end
            end
            TX_CMD: begin
                if (busy_fall_s) begin
                    issue_s   = 1'b1;
                    byte_s    = tx_cmd_r;
                    tx_next_s = TX_LEN;
                end else begin
                    tx_next_s = TX_CMD;
                end
            end
            TX_LEN: begin
                if (busy_fall_s) begin
                    issue_s   = 1'b1;
                    byte_s    = tx_len_r;
                    tx_next_s = TX_DATA;
                end else begin
                    tx_next_s = TX_LEN;
                end
            end
            TX_DATA: begin
                if (busy_fall_s) begin
                    issue_s   = 1'b1;
                    idx_inc_s = 1'b1;
                    byte_s    = pay_byte_s;
                    tx_next_s = (tx_idx_r == tx_len_r - 8'd1) ? TX_CHK : TX_DATA;
                end else begin
                    tx_next_s = TX_DATA;
                end
            end
            TX_CHK: begin
                if (busy_fall_s) begin
                    issue_s   = 1'b1;
                    byte_s    = tx_chk_r;
                    tx_next_s = TX_IDLE;
                end else begin
                    tx_next_s = TX_CHK;
                end
            end
            default: tx_next_s = TX_IDLE;
        endcase
    end

    // Tx state, held frame contents and registered byte strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_r    <= TX_IDLE;
            tx_cmd_r      <= 8'h00;
            tx_len_r      <= 8'h00;
            tx_chk_r      <= 8'h00;
            tx_idx_r      <= 8'h00;
            tx_pay_r      <= '0;
            busy_d_r      <= 1'b0;
            tx_data_r     <= 8'h00;
            new_tx_data_r <= 1'b0;
        end else begin
            tx_state_r    <= tx_next_s;
            busy_d_r      <= tx_busy;
            new_tx_data_r <= issue_s;
            tx_data_r     <= byte_s;
            if (load_frame_s) begin
                tx_cmd_r <= frame_cmd_s;
                tx_len_r <= frame_len_s;
                tx_pay_r <= frame_pay_s;
                tx_chk_r <= frame_cmd_s ^ frame_len_s ^ xor_bytes(frame_pay_s);
                tx_idx_r <= 8'h00;
            end else if (idx_inc_s) begin
                tx_idx_r <= tx_idx_r + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser (FIFO_DEPTH 2).
module tb_uart_frame_parser;
    localparam int WB = 80;
    localparam int TB = 4;
    localparam int CH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              new_rx_data;
    logic [7:0]        tx_data;
    logic              new_tx_data;
    logic              tx_busy;
    logic              valid;
    logic [8*WB-1:0]   work;
    logic [8*TB-1:0]   target;
    logic [CH-1:0]     found;
    logic [CH*32-1:0]  nonce;
    logic [7:0]        drop_count;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                valid_cnt = 0;
    int                busy_cnt = 0;
    bit                start_q  = 1'b0;
    logic              force_busy;
    logic [7:0]        txq [$];
    logic [7:0]        exp_q [$];
    logic [7:0]        frame_data [256];
    logic [8*WB-1:0]   exp_work;
    logic [8*TB-1:0]   exp_target;
    int                v0, sz0;

    uart_frame_parser #(.FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
        .valid(valid), .work(work), .target(target), .found(found), .nonce(nonce),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    // Transmitter model: busy rises the cycle after each strobe, lasts 8 cycles.
    always @(negedge clock) begin
        if (busy_cnt != 0) busy_cnt--;
        if (start_q) busy_cnt = 8;
        start_q = new_tx_data;
        if (new_tx_data) txq.push_back(tx_data);
        tx_busy = force_busy || (busy_cnt != 0);
    end

    // Count valid pulses.
    always @(negedge clock) begin
        if (valid) valid_cnt++;
    end

    task automatic check_eq(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; new_rx_data = 1'b1;
        @(negedge clock);
        rx_data = 8'h00; new_rx_data = 1'b0;
        @(negedge clock);
    endtask

    // Sends AA,cmd,len,frame_data[0..len-1],chk (chk optionally corrupted).
    task automatic send_frame(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                              input bit bad, input logic exp_valid);
        logic [7:0] chk;
        chk = cmd ^ len;
        send_byte(8'hAA); send_byte(cmd); send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            chk = chk ^ frame_data[i];
            send_byte(frame_data[i]);
        end
        if (bad) chk = ~chk;
        rx_data = chk; new_rx_data = 1'b1;
        @(negedge clock);
        rx_data = 8'h00; new_rx_data = 1'b0;
        check_eq({tag, " valid_pulse"}, 640'(valid), 640'(exp_valid));
        @(negedge clock);
        check_eq({tag, " valid_low"}, 640'(valid), 640'd0);
    endtask

    // Waits for exp_q.size() transmitted bytes and compares them in order.
    task automatic check_frame(input string tag);
        for (int k = 0; k < 600 && txq.size() < exp_q.size(); k++) @(negedge clock);
        check_eq({tag, " byte_count_ok"}, 640'(txq.size() >= exp_q.size()), 640'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (txq.size() > 0) begin
                check_eq($sformatf("%s byte%0d", tag, i), 640'(txq.pop_front()), 640'(exp_q[i]));
            end
        end
        exp_q.delete();
    endtask

    task automatic pulse_found(input logic [CH-1:0] f, input logic [CH*32-1:0] n);
        found = f; nonce = n;
        @(negedge clock);
        found = '0; nonce = '0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rx_data = 8'h00; new_rx_data = 1'b0;
        found = '0; nonce = '0; force_busy = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst valid", 640'(valid), 640'd0);
        check_eq("rst work", work, 640'd0);
        check_eq("rst target", 640'(target), 640'd0);
        check_eq("rst tx_data", 640'(tx_data), 640'd0);
        check_eq("rst new_tx_data", 640'(new_tx_data), 640'd0);
        check_eq("rst drop_count", 640'(drop_count), 640'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Good work frame, bytes 0x00..0x53.
        for (int i = 0; i < 84; i++) frame_data[i] = 8'(i);
        for (int i = 0; i < 80; i++) exp_work[8*i +: 8] = 8'(i);
        v0 = valid_cnt;
        send_frame("work_good", 8'h00, 8'h54, 1'b0, 1'b1);
        check_eq("work_good pulses", 640'(valid_cnt - v0), 640'd1);
        check_eq("work_good work", work, exp_work);
        check_eq("work_good work_lsb", 640'(work[7:0]), 640'h00);
        check_eq("work_good target", 640'(target), 640'h53525150);

        // Bad checksum with different data: nothing loads, NACK of CMD 0x00.
        for (int i = 0; i < 84; i++) frame_data[i] = 8'(8'hFF - 8'(i));
        v0 = valid_cnt;
        send_frame("work_bad", 8'h00, 8'h54, 1'b1, 1'b0);
        check_eq("work_bad pulses", 640'(valid_cnt - v0), 640'd0);
        check_eq("work_bad work", work, exp_work);
        check_eq("work_bad target", 640'(target), 640'h53525150);
        exp_q = '{8'h55, 8'h7F, 8'h01, 8'h00, 8'h7E};
        check_frame("nack");

        // Loop test with D = 0x41.
        frame_data[0] = 8'h41;
        send_frame("loop", 8'h01, 8'h01, 1'b0, 1'b0);
        exp_q = '{8'h55, 8'h01, 8'h01, 8'h42, 8'h42};
        check_frame("loop_ack");

        // Channels 1 and 3 in the same cycle.
        pulse_found(4'b1010, {32'hA5A5A5A5, 32'h0, 32'h11223344, 32'h0});
        exp_q = '{8'h55, 8'h00, 8'h05, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h40};
        check_frame("found_ch1");
        exp_q = '{8'h55, 8'h00, 8'h05, 8'h03, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h06};
        check_frame("found_ch3");
        repeat (20) @(negedge clock);
        check_eq("found idle", 640'(txq.size()), 640'd0);

        // Channel 2 with the transmitter held busy: 2 in FIFO, 1 pending, then a drop.
        force_busy = 1'b1;
        repeat (2) @(negedge clock);
        for (int p = 1; p <= 3; p++) pulse_found(4'b0100, {32'h0, 32'hC0DE0000 | 32'(p), 64'h0});
        check_eq("ch2 no_drop", 640'(drop_count), 640'd0);
        pulse_found(4'b0100, {32'h0, 32'hC0DE0004, 64'h0});
        check_eq("ch2 one_drop", 640'(drop_count), 640'd1);
        check_eq("ch2 held", 640'(txq.size()), 640'd0);
        force_busy = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            exp_q = '{8'h55, 8'h00, 8'h05, 8'h02, 8'(p), 8'h00, 8'hDE, 8'hC0, 8'h19 ^ 8'(p)};
            check_frame($sformatf("ch2_frame%0d", p));
        end
        repeat (40) @(negedge clock);
        check_eq("ch2 no_fourth", 640'(txq.size()), 640'd0);
        check_eq("ch2 drop_kept", 640'(drop_count), 640'd1);

        // Reset mid-frame while a NACK response is being sent.
        frame_data[0] = 8'h41;
        send_frame("loop_bad", 8'h01, 8'h01, 1'b1, 1'b0);
        send_byte(8'hAA); send_byte(8'h00); send_byte(8'h54);
        for (int i = 0; i < 10; i++) send_byte(8'h77);
        reset = 1'b1;
        #1;
        sz0 = txq.size();
        @(negedge clock);
        check_eq("midrst valid", 640'(valid), 640'd0);
        check_eq("midrst work", work, 640'd0);
        check_eq("midrst target", 640'(target), 640'd0);
        check_eq("midrst drop_count", 640'(drop_count), 640'd0);
        check_eq("midrst new_tx_data", 640'(new_tx_data), 640'd0);
        check_eq("midrst tx_data", 640'(tx_data), 640'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (80) @(negedge clock);
        check_eq("midrst no_more_bytes", 640'(txq.size()), 640'(sz0));

        // Good frame after reset with a fresh pattern.
        for (int i = 0; i < 84; i++) frame_data[i] = 8'((i * 7 + 3) & 255);
        for (int i = 0; i < 80; i++) exp_work[8*i +: 8] = frame_data[i];
        for (int i = 0; i < 4; i++) exp_target[8*i +: 8] = frame_data[80 + i];
        v0 = valid_cnt;
        send_frame("post_rst", 8'h00, 8'h54, 1'b0, 1'b1);
        check_eq("post_rst pulses", 640'(valid_cnt - v0), 640'd1);
        check_eq("post_rst work", work, exp_work);
        check_eq("post_rst target", 640'(target), 640'(exp_target));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
